// File: rtl/sobel_ctrl_pkg.sv
// sobel_ctrl_pkg: FSM encoding, window constant and counter-width helper for the Sobel frame controller.
package sobel_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_FILL       = 3'd2,
        S_ACTIVE     = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    // First row/column whose 3x3 window is complete
    localparam int WIN_FIRST = 2;

    function automatic int calc_cnt_w(input int w, input int h);
        return $clog2((w > h ? w : h) + 1);
    endfunction

endpackage

// File: rtl/sobel_mask_delay.sv
// sobel_mask_delay: LAT-deep shift register that aligns the window mask with the Sobel result; resets to masked.
module sobel_mask_delay #(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] sr;

    always_ff @(posedge clk) begin
        if (!reset_n) sr <= '1;
        else sr <= LAT'({sr, din});
    end

    assign dout = sr[LAT-1];

endmodule

// File: rtl/sobel_ctrl.sv
// sobel_ctrl: frame FSM, row/column counters, window mask and per-frame threshold shadow for the Sobel stage.
module sobel_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int IMG_WIDTH      = 640,
    parameter int IMG_HEIGHT     = 480,
    parameter int CNT_W          = 12,
    parameter int THRESH_DEFAULT = 50,
    parameter int PIPE_LAT       = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_enable,
    input  logic [DATA_WIDTH+1:0] cfg_threshold,
    input  logic                  cfg_update,
    input  logic                  pix_valid,
    input  logic                  pix_hsync,
    input  logic                  pix_vsync,
    output logic                  sobel_en,
    output logic [DATA_WIDTH+1:0] thresh_active,
    output logic [CNT_W-1:0]      row_cnt,
    output logic [CNT_W-1:0]      col_cnt,
    output logic                  sobel_mask,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  geom_err
);

    state_t                state;
    logic                  vs_q, hs_q, pend;
    logic [DATA_WIDTH+1:0] thr_pend;
    logic                  accept, run, vs_rise, vs_fall, hs_fall, raw_mask;

    assign accept   = pix_valid & pix_hsync & pix_vsync;
    assign run      = (state == S_FILL) || (state == S_ACTIVE);
    assign vs_rise  = pix_vsync & ~vs_q;
    assign vs_fall  = ~pix_vsync & vs_q;
    assign hs_fall  = ~pix_hsync & hs_q;
    assign raw_mask = ~(run & accept) | (row_cnt < CNT_W'(WIN_FIRST)) | (col_cnt < CNT_W'(WIN_FIRST));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            vs_q          <= 1'b1;
            hs_q          <= 1'b0;
            pend          <= 1'b0;
            thr_pend      <= (DATA_WIDTH+2)'(THRESH_DEFAULT);
            thresh_active <= (DATA_WIDTH+2)'(THRESH_DEFAULT);
            sobel_en      <= 1'b0;
            row_cnt       <= '0;
            col_cnt       <= '0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            geom_err      <= 1'b0;
        end else begin
            // vs_q resets high so a frame already in progress at reset release is not joined
            vs_q        <= pix_vsync;
            hs_q        <= pix_hsync;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            if (cfg_update) begin
                thr_pend <= cfg_threshold;
                pend     <= 1'b1;
            end
            if (run) begin
                if (accept) col_cnt <= col_cnt + 1'b1;
                if (hs_fall) begin
                    col_cnt <= '0;
                    if (row_cnt != '1) row_cnt <= row_cnt + 1'b1;
                    if (col_cnt != CNT_W'(IMG_WIDTH)) geom_err <= 1'b1;
                end
                if (vs_fall && row_cnt != CNT_W'(IMG_HEIGHT)) geom_err <= 1'b1;
            end
            case (state)
                S_IDLE: if (cfg_enable) state <= S_WAIT_FRAME;
                S_WAIT_FRAME: begin
                    if (vs_rise) begin
                        state         <= S_FILL;
                        frame_start   <= 1'b1;
                        sobel_en      <= 1'b1;
                        row_cnt       <= '0;
                        col_cnt       <= '0;
                        geom_err      <= 1'b0;
                        thresh_active <= cfg_update ? cfg_threshold : pend ? thr_pend : thresh_active;
                        pend          <= 1'b0;
                    end
                end
                S_FILL, S_ACTIVE: begin
                    if (vs_fall) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                        sobel_en   <= 1'b0;
                    end else if (state == S_FILL && row_cnt >= CNT_W'(WIN_FIRST)) begin
                        state <= S_ACTIVE;
                    end
                end
                S_DONE: state <= cfg_enable ? S_WAIT_FRAME : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    sobel_mask_delay #(.LAT(PIPE_LAT)) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (raw_mask),
        .dout    (sobel_mask)
    );

endmodule

// File: doc/sobel_ctrl.md
# sobel_ctrl

Frame-level controller for the Sobel edge-detection stage. It tracks the median-filtered pixel stream with row and column counters and enables the Sobel datapath once per frame. It flags pixels whose 3x3 window is incomplete, and delivers a per-frame-stable threshold through a shadow register. It sits beside the Sobel datapath, between the median filter output and the binary-image consumer.

## Interface
- DATA_WIDTH, 8, gray pixel width; threshold width is DATA_WIDTH+2.
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- CNT_W, 12, row/column counter width; must satisfy 2^CNT_W > max(IMG_WIDTH, IMG_HEIGHT).
- THRESH_DEFAULT, 50, threshold value after reset.
- PIPE_LAT, 3, Sobel input-to-output latency in cycles.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- cfg_enable  in  1  level; 1 = process frames.
- cfg_threshold  in  DATA_WIDTH+2  new threshold value.
- cfg_update  in  1  one-cycle strobe that captures cfg_threshold.
- pix_valid  in  1  median output valid.
- pix_hsync  in  1  line active (high).
- pix_vsync  in  1  frame active (high).
- sobel_en  out  1  datapath enable.
- thresh_active  out  DATA_WIDTH+2  threshold in force for the current frame.
- row_cnt  out  CNT_W  current line index.
- col_cnt  out  CNT_W  pixels accepted in the current line.
- sobel_mask  out  1  1 = force output pixel white (incomplete window); aligned to Sobel output.
- frame_start  out  1  one-cycle pulse.
- frame_done  out  1  one-cycle pulse.
- geom_err  out  1  sticky geometry error.

## Operation
- A pixel is accepted when pix_valid, pix_hsync and pix_vsync are all 1.
- FSM states are IDLE, WAIT_FRAME, FILL, ACTIVE and DONE.
  - IDLE: waits for cfg_enable=1, then goes to WAIT_FRAME.
  - WAIT_FRAME: on a pix_vsync rising edge, pulses frame_start, clears the counters and geom_err, and goes to FILL.
  - FILL: rows 0–1, where the window is incomplete. Moves to ACTIVE when row_cnt reaches 2.
  - ACTIVE: runs until the pix_vsync falling edge, then goes to DONE.
  - DONE: pulses frame_done for one cycle, then goes to WAIT_FRAME if cfg_enable=1, else IDLE.
- Vsync falling during FILL also goes to DONE.
- After reset with pix_vsync already high, the block must not join mid-frame; it waits for the next rising edge.
- cfg_enable deasserted mid-frame: the current frame completes first.
- Counters:
  - col_cnt increments on each accepted pixel.
  - On a pix_hsync falling edge, col_cnt clears and row_cnt increments.
  - row_cnt saturates at 2^CNT_W−1.
- geom_err sets when:
  - a hsync fall occurs with col_cnt≠IMG_WIDTH, or
  - a vsync fall occurs with row_cnt≠IMG_HEIGHT.
  - It clears only at frame_start or reset.
- Mask: for an accepted pixel, the raw mask is 1 if row_cnt<2 or col_cnt<2, evaluated before the increment. The raw mask is delayed PIPE_LAT cycles to form sobel_mask.
- Threshold:
  - cfg_update loads a pending register and sets a pending flag.
  - At frame_start, the pending value moves to thresh_active and the flag clears.
  - If cfg_update coincides with frame_start, the new cfg_threshold takes effect for this frame.
  - thresh_active is never changed mid-frame.
- sobel_en=1 in FILL and ACTIVE.

## Timing
- Reset values:
  - sobel_en=0, thresh_active=THRESH_DEFAULT, pending flag=0.
  - row_cnt=0, col_cnt=0.
  - sobel_mask=1, frame_start=0, frame_done=0, geom_err=0.
  - FSM in IDLE.
  - Delay-line contents are all 1 (masked).
- Edge detection uses 1-cycle registered copies of the syncs. frame_start asserts the cycle after vsync is sampled high following a sampled low.
- Counter updates are visible 1 cycle after the accepted pixel or hsync edge.
- sobel_mask for the pixel accepted in cycle t is valid in cycle t+PIPE_LAT, co-timed with the Sobel result.
- frame_done asserts 1 cycle after the vsync fall is detected. A vsync rise in the DONE cycle is missed, so the minimum vertical blank is 2 cycles.
- reset_n low in any cycle overrides all other inputs.

## Structure
- Package sobel_ctrl_pkg holds:
  - the FSM state localparams (3-bit encoding);
  - the constant 2 (first complete window row/column);
  - a function computing CNT_W from the dimensions.
- One sub-module: sobel_mask_delay, a parameterized PIPE_LAT-deep shift register with a reset value of 1.
- All other logic lives in sobel_ctrl.

## Test plan
- Reset then 4x4 frame (IMG_WIDTH=IMG_HEIGHT=4) → frame_start 1 cycle after vsync rise. sobel_mask=0 only for pixels (2,2),(2,3),(3,2),(3,3), each 3 cycles after acceptance. frame_done after vsync fall, geom_err=0.
- cfg_update with 80 mid-frame → thresh_active holds 50 to the end of the frame; becomes 80 at the next frame_start.
- cfg_update with 120 in the same cycle as the vsync-rise detection → thresh_active=120 for that frame.
- One line of 3 pixels in a 4-wide frame → geom_err=1 after that hsync fall, staying set until the next frame_start.
- Reset released mid-frame with vsync high → no frame_start until the next rise. sobel_en=0 meanwhile.
- cfg_enable dropped in row 1 → the frame completes with frame_done, then the FSM enters IDLE; the next vsync rise is ignored.
